// File: rtl/alarm_pkg.sv
// Shared encodings and widths for the alarm path: FSM states, time field widths
// and the hour value that marks "no alarm set".
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] NOALARM       = 5'd24;
    localparam logic [HOUR_W-1:0] HOURS_PER_DAY = 5'd24;
    localparam logic [MIN_W:0]    MIN_PER_HOUR  = 7'd60;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZED = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/time_add_minutes.sv
// Combinational hours:minutes + K with minute carry into the hour and
// midnight wrap of the hour.
module time_add_minutes
    import alarm_pkg::*;
#(
    parameter int K = 5
) (
    input  logic [HOUR_W-1:0] hours,
    input  logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] sum_hours,
    output logic [MIN_W-1:0]  sum_minutes
);

    logic [MIN_W:0]    m_sum;
    logic [HOUR_W-1:0] h_sum;

    always_comb begin
        m_sum = {1'b0, minutes} + 7'(K);
        h_sum = hours;
        if (m_sum >= MIN_PER_HOUR) begin
            m_sum = m_sum - MIN_PER_HOUR;
            h_sum = hours + 5'd1;
        end
        if (h_sum >= HOURS_PER_DAY) begin
            h_sum = '0;
        end
        sum_hours   = h_sum;
        sum_minutes = m_sum[MIN_W-1:0];
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencing FSM: arm/disarm from the stored setting, ring on the minute
// boundary, stop/snooze/timeout handling. Snooze is built only with ALARM_SNOOZE_EN.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    input  logic [MIN_W-1:0]  cur_seconds,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    input  logic              stop,
    input  logic              snooze,
    output logic              ring,
    output logic              snooze_active,
    output logic [HOUR_W-1:0] next_hours,
    output logic [MIN_W-1:0]  next_minutes,
    output logic [1:0]        state
);

    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

    alarm_state_t      state_q;
    logic [HOUR_W-1:0] prev_hours;
    logic [MIN_W-1:0]  prev_minutes;
    logic [7:0]        ring_cnt;
    logic              snz_q;

    logic no_alarm;
    logic setting_change;
    logic match;

    assign no_alarm       = (alarm_hours >= NOALARM);
    assign setting_change = (alarm_hours != prev_hours) || (alarm_minutes != prev_minutes);
    assign match          = sec_tick && (cur_seconds == '0) &&
                            (cur_hours == next_hours) && (cur_minutes == next_minutes);

`ifdef ALARM_SNOOZE_EN
    logic [HOUR_W-1:0] snz_hours;
    logic [MIN_W-1:0]  snz_minutes;

    time_add_minutes #(.K(SNOOZE_MIN)) u_snooze_add (
        .hours       (cur_hours),
        .minutes     (cur_minutes),
        .sum_hours   (snz_hours),
        .sum_minutes (snz_minutes)
    );

    assign snooze_active = snz_q;
`else
    logic unused_snooze;
    assign unused_snooze = ^{snooze, snz_q, 32'(SNOOZE_MIN)};
    assign snooze_active = 1'b0;
`endif

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ring         <= 1'b0;
            snz_q        <= 1'b0;
            next_hours   <= NOALARM;
            next_minutes <= '0;
            ring_cnt     <= '0;
            prev_hours   <= NOALARM;
            prev_minutes <= '0;
        end else begin
            prev_hours   <= alarm_hours;
            prev_minutes <= alarm_minutes;

            case (state_q)
                IDLE: begin
                    if (!no_alarm) begin
                        state_q      <= ARMED;
                        next_hours   <= alarm_hours;
                        next_minutes <= alarm_minutes;
                    end
                end

                ARMED: begin
                    if (no_alarm) begin
                        state_q      <= IDLE;
                        next_hours   <= NOALARM;
                        next_minutes <= '0;
                    end else begin
                        // A match compares against the old target even if the setting moves now.
                        if (match) begin
                            state_q  <= RINGING;
                            ring     <= 1'b1;
                            ring_cnt <= '0;
                        end
                        if (setting_change) begin
                            next_hours   <= alarm_hours;
                            next_minutes <= alarm_minutes;
                        end
                    end
                end

                RINGING: begin
                    if (no_alarm) begin
                        state_q      <= IDLE;
                        ring         <= 1'b0;
                        next_hours   <= NOALARM;
                        next_minutes <= '0;
                    end else if (stop) begin
                        state_q      <= ARMED;
                        ring         <= 1'b0;
                        next_hours   <= alarm_hours;
                        next_minutes <= alarm_minutes;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_q      <= SNOOZED;
                        ring         <= 1'b0;
                        snz_q        <= 1'b1;
                        next_hours   <= snz_hours;
                        next_minutes <= snz_minutes;
`endif
                    end else if (setting_change || (sec_tick && ring_cnt == RING_LAST)) begin
                        state_q      <= ARMED;
                        ring         <= 1'b0;
                        next_hours   <= alarm_hours;
                        next_minutes <= alarm_minutes;
                    end else if (sec_tick) begin
                        ring_cnt <= ring_cnt + 8'd1;
                    end
                end

                SNOOZED: begin
                    if (no_alarm) begin
                        state_q      <= IDLE;
                        snz_q        <= 1'b0;
                        next_hours   <= NOALARM;
                        next_minutes <= '0;
                    end else if (stop || setting_change) begin
                        state_q      <= ARMED;
                        snz_q        <= 1'b0;
                        next_hours   <= alarm_hours;
                        next_minutes <= alarm_minutes;
                    end else if (match) begin
                        state_q  <= RINGING;
                        ring     <= 1'b1;
                        snz_q    <= 1'b0;
                        ring_cnt <= '0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    ring    <= 1'b0;
                    snz_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
